// File: rtl/decode_pkg.sv
// Shared decode definitions: multi-cycle operation types and the default multiplier latency.
// Used by both the instruction decoder and the multiply/divide controller.
package decode_pkg;

   typedef enum logic [2:0] {
      M_MULT  = 3'd0,
      M_MULTU = 3'd1,
      M_DIV   = 3'd2,
      M_DIVU  = 3'd3,
      M_MADD  = 3'd4,
      M_MADDU = 3'd5,
      M_MSUB  = 3'd6,
      M_MSUBU = 3'd7
   } multicycle_t;

   localparam int MUL_CYCLES_DEFAULT = 3;

   function automatic logic is_div_op(input multicycle_t op);
      return (op == M_DIV) || (op == M_DIVU);
   endfunction

   function automatic logic is_signed_op(input multicycle_t op);
      return (op == M_MULT) || (op == M_DIV) || (op == M_MADD) || (op == M_MSUB);
   endfunction

   // MADD*/MSUB* need the extra accumulate cycle after the multiply
   function automatic logic is_acc_op(input multicycle_t op);
      return (op == M_MADD) || (op == M_MADDU) || (op == M_MSUB) || (op == M_MSUBU);
   endfunction

   function automatic logic is_sub_op(input multicycle_t op);
      return (op == M_MSUB) || (op == M_MSUBU);
   endfunction

endpackage

// File: rtl/div_radix2.sv
// Radix-2 restoring divider on operand magnitudes: one setup cycle, 32 iterations,
// then a sign-fixup cycle in which done is high and the results are valid.
module div_radix2 (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic        abort,
   input  logic        is_signed,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);

   typedef enum logic [1:0] {D_IDLE, D_ITER, D_FIX} dstate_t;

   dstate_t     state;
   logic [4:0]  iter_cnt;
   logic [31:0] rem, quo, dvs;
   logic        neg_q, neg_r;
   logic [32:0] shifted;
   logic        fits;
   logic [31:0] rem_nxt;

   always_comb begin
      shifted = {rem, quo[31]};
      fits    = shifted >= {1'b0, dvs};
      rem_nxt = fits ? 32'(shifted - {1'b0, dvs}) : shifted[31:0];
   end

   assign busy      = (state != D_IDLE);
   assign done      = (state == D_FIX);
   assign quotient  = neg_q ? -quo : quo;
   assign remainder = neg_r ? -rem : rem;

   // A zero divisor never fails the trial subtraction, so the quotient
   // fills with ones and the dividend magnitude ends up in the remainder.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= D_IDLE;
         iter_cnt <= '0;
         rem      <= '0;
         quo      <= '0;
         dvs      <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
      end else if (abort) begin
         state    <= D_IDLE;
         iter_cnt <= '0;
      end else begin
         case (state)
            D_IDLE: if (start) begin
               rem      <= '0;
               quo      <= (is_signed && a[31]) ? -a : a;
               dvs      <= (is_signed && b[31]) ? -b : b;
               neg_q    <= is_signed && (a[31] ^ b[31]);
               neg_r    <= is_signed && a[31];
               iter_cnt <= 5'd31;
               state    <= D_ITER;
            end
            D_ITER: begin
               rem <= rem_nxt;
               quo <= {quo[30:0], fits};
               if (iter_cnt == '0) state <= D_FIX;
               else iter_cnt <= iter_cnt - 5'd1;
            end
            D_FIX:   state <= D_IDLE;
            default: state <= D_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/multdiv_ctrl.sv
// Multi-cycle multiply / multiply-accumulate / divide controller for the execute stage.
// Operands are captured in the accepting cycle; HI/LO results are registered on entry to DONE.
module multdiv_ctrl
   import decode_pkg::*;
#(
   parameter int MUL_CYCLES = MUL_CYCLES_DEFAULT
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        valid,
   input  multicycle_t mtype,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] hi_in,
   input  logic [31:0] lo_in,
   input  logic        flush,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out
);

   typedef enum logic [2:0] {S_IDLE, S_MUL, S_ACC, S_DIV, S_DONE} state_t;

   state_t      state, state_nxt;
   logic [7:0]  cnt;
   multicycle_t op_q;
   logic [31:0] a_q, b_q, hi_q, lo_q;
   logic        accept, load_res, div_start;
   logic [63:0] res_nxt, product, acc_sum;
   logic        div_busy, div_done;
   logic [31:0] div_q, div_r;
   logic        sgn;

   // Sign-extending to 64 bits makes one unsigned multiply serve both signednesses
   always_comb begin
      sgn     = is_signed_op(op_q);
      product = {{32{sgn & a_q[31]}}, a_q} * {{32{sgn & b_q[31]}}, b_q};
      acc_sum = is_sub_op(op_q) ? ({hi_q, lo_q} - product) : ({hi_q, lo_q} + product);
   end

   div_radix2 u_div (
      .clk       (clk),
      .resetn    (resetn),
      .start     (div_start),
      .abort     (flush),
      .is_signed (sgn),
      .a         (a_q),
      .b         (b_q),
      .busy      (div_busy),
      .done      (div_done),
      .quotient  (div_q),
      .remainder (div_r)
   );

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
      load_res  = 1'b0;
      div_start = 1'b0;
      res_nxt   = product;
      case (state)
         S_IDLE: if (valid && !flush) begin
            accept    = 1'b1;
            busy      = 1'b1;
            state_nxt = is_div_op(mtype) ? S_DIV : S_MUL;
         end
         S_MUL: begin
            busy = 1'b1;
            if (cnt == '0) begin
               if (is_acc_op(op_q)) state_nxt = S_ACC;
               else begin
                  state_nxt = S_DONE;
                  load_res  = 1'b1;
               end
            end
         end
         S_ACC: begin
            busy      = 1'b1;
            state_nxt = S_DONE;
            load_res  = 1'b1;
            res_nxt   = acc_sum;
         end
         S_DIV: begin
            busy      = 1'b1;
            div_start = !div_busy;
            res_nxt   = {div_r, div_q};
            if (div_done) begin
               state_nxt = S_DONE;
               load_res  = 1'b1;
            end
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      // A flush kills whatever is in flight without touching the results
      if (flush) begin
         state_nxt = S_IDLE;
         load_res  = 1'b0;
         done      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state  <= S_IDLE;
         cnt    <= '0;
         hi_out <= '0;
         lo_out <= '0;
         op_q   <= M_MULT;
         a_q    <= '0;
         b_q    <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            op_q <= mtype;
            a_q  <= a;
            b_q  <= b;
            hi_q <= hi_in;
            lo_q <= lo_in;
            cnt  <= 8'(MUL_CYCLES - 1);
         end else if (flush) begin
            cnt <= '0;
         end else if (state == S_MUL && cnt != '0) begin
            cnt <= cnt - 8'd1;
         end
         if (load_res) {hi_out, lo_out} <= res_nxt;
      end
   end

endmodule
